// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU (alu_seq):
//   - 3-bit operation codes (clr, pass, add, sub, mul, inc, idle; 7 = idle)
//   - FSM state encoding (IDLE / MUL / DONE)
//   - sat_max / sat_min: signed range limits for a given width
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [2:0] OP_CLR  = 3'd0;
  localparam logic [2:0] OP_PASS = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_MUL  = 3'd4;
  localparam logic [2:0] OP_INC  = 3'd5;
  localparam logic [2:0] OP_IDLE = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Largest representable signed value at the given width: 2^(w-1)-1
  function automatic longint sat_max(int width);
    return (longint'(1) <<< (width - 1)) - 1;
  endfunction

  // Smallest representable signed value at the given width: -2^(w-1)
  function automatic longint sat_min(int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if
// Op request / result bundle between the control FSM (master) and alu_seq
// (slave).
//   start, selectOp, a, b           : master -> slave
//   ready, done, dataOut,
//   zeroFlag, ovfFlag               : slave -> master
// ---------------------------------------------------------------------------
interface alu_seq_if #(
  parameter int WIDTH = 12
);
  logic                    start;
  logic [2:0]              selectOp;
  logic signed [WIDTH-1:0] a;
  logic signed [WIDTH-1:0] b;
  logic                    ready;
  logic                    done;
  logic signed [WIDTH-1:0] dataOut;
  logic                    zeroFlag;
  logic                    ovfFlag;

  modport master (
    output start, selectOp, a, b,
    input  ready, done, dataOut, zeroFlag, ovfFlag
  );

  modport slave (
    input  start, selectOp, a, b,
    output ready, done, dataOut, zeroFlag, ovfFlag
  );
endinterface

// File: rtl/alu_mul_iter.sv
// ---------------------------------------------------------------------------
// alu_mul_iter
// Unsigned iterative shift-add multiplier, one partial product per step.
//   clk, rstN     : clock, asynchronous active-low reset
//   load          : capture magnitudes, clear product and step counter
//   step          : perform one shift-add step
//   mag_a, mag_b  : unsigned WIDTH-bit magnitudes
//   product       : accumulator value *after* the current step (combinational),
//                   so the caller can register the final product on the last step
//   last          : high during the final (WIDTH-th) step
// ---------------------------------------------------------------------------
module alu_mul_iter #(
  parameter int WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     mag_a,
  input  logic [WIDTH-1:0]     mag_b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 last
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier_reg;
  logic [CW-1:0]      cnt_reg;

  // Add the shifted multiplicand when the current multiplier LSB is set
  assign acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
  assign product  = acc_next;
  assign last     = step && (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mcand_reg  <= '0;
      acc_reg    <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
    end else if (load) begin
      mcand_reg  <= {{WIDTH{1'b0}}, mag_a};
      mplier_reg <= mag_b;
      acc_reg    <= '0;
      cnt_reg    <= '0;
    end else if (step) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Registered, handshaked ALU with an iterative multiplier.
//   clk   : rising-edge clock
//   rstN  : asynchronous active-low reset
//   bus   : alu_seq_if.slave -- start/selectOp/a/b in,
//           ready/done/dataOut/zeroFlag/ovfFlag out
// Ops: clr, pass, add, sub, inc complete in one cycle; mul takes WIDTH cycles;
// idle (and code 7) just pulses done without touching the result.
// Optional feature: define ALU_SAT_EN to clamp overflowing results to the
// signed range limits instead of wrapping. ovfFlag behaves the same either way.
// ---------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input logic       clk,
  input logic       rstN,
  alu_seq_if.slave  bus
);

`ifdef ALU_SAT_EN
  localparam logic signed [WIDTH-1:0] MAX_V = WIDTH'(sat_max(WIDTH));
  localparam logic signed [WIDTH-1:0] MIN_V = WIDTH'(sat_min(WIDTH));
`endif

  state_t                  state_reg, state_next;
  logic signed [WIDTH-1:0] data_reg, data_next;
  logic                    zero_reg, zero_next;
  logic                    ovf_reg, ovf_next;
  logic                    sign_reg, sign_next;

  logic                    mul_load, mul_step, mul_last;
  logic [WIDTH-1:0]        mag_a, mag_b;
  logic [2*WIDTH-1:0]      product;
  logic [2*WIDTH-1:0]      prod_signed;
  logic [WIDTH:0]          prod_hi;

  logic signed [WIDTH:0]   a_ext, b_ext, sum_wide;

  logic                    update;
  logic [WIDTH-1:0]        res_wrap;
  logic                    res_ovf;
  logic signed [WIDTH-1:0] res_final;
`ifdef ALU_SAT_EN
  logic                    res_neg;
`endif

  // Magnitudes fit in WIDTH unsigned bits, including |-2^(W-1)| = 2^(W-1)
  assign mag_a = bus.a[WIDTH-1] ? WIDTH'(-bus.a) : bus.a;
  assign mag_b = bus.b[WIDTH-1] ? WIDTH'(-bus.b) : bus.b;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rstN    (rstN),
    .load    (mul_load),
    .step    (mul_step),
    .mag_a   (mag_a),
    .mag_b   (mag_b),
    .product (product),
    .last    (mul_last)
  );

  // Signed product; overflow when the top WIDTH+1 bits are not a pure sign extension
  assign prod_signed = sign_reg ? (~product + 1'b1) : product;
  assign prod_hi     = prod_signed[2*WIDTH-1:WIDTH-1];

  // Single-cycle ops evaluated one bit wider so the true result is exact
  assign a_ext = {bus.a[WIDTH-1], bus.a};
  assign b_ext = {bus.b[WIDTH-1], bus.b};

  always_comb begin
    sum_wide = '0;
    case (bus.selectOp)
      OP_PASS: sum_wide = a_ext;
      OP_ADD:  sum_wide = a_ext + b_ext;
      OP_SUB:  sum_wide = a_ext - b_ext;
      OP_INC:  sum_wide = a_ext + (WIDTH+1)'(1);
      default: sum_wide = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      zero_reg  <= 1'b1;
      ovf_reg   <= 1'b0;
      sign_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      zero_reg  <= zero_next;
      ovf_reg   <= ovf_next;
      sign_reg  <= sign_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    zero_next  = zero_reg;
    ovf_next   = ovf_reg;
    sign_next  = sign_reg;
    mul_load   = 1'b0;
    mul_step   = 1'b0;
    update     = 1'b0;
    res_wrap   = '0;
    res_ovf    = 1'b0;
`ifdef ALU_SAT_EN
    res_neg    = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if (bus.selectOp == OP_MUL) begin
            mul_load   = 1'b1;
            sign_next  = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            state_next = MUL;
          end else begin
            state_next = DONE;
            // clr/pass/add/sub/inc produce a result; idle and 7 leave it alone.
            // clr and pass can never disagree in the top two bits, so their
            // overflow is inherently 0.
            if (bus.selectOp <= OP_INC) begin
              update   = 1'b1;
              res_wrap = sum_wide[WIDTH-1:0];
              res_ovf  = sum_wide[WIDTH] ^ sum_wide[WIDTH-1];
`ifdef ALU_SAT_EN
              res_neg  = sum_wide[WIDTH];
`endif
            end
          end
        end
      end
      MUL: begin
        mul_step = 1'b1;
        if (mul_last) begin
          update     = 1'b1;
          res_wrap   = prod_signed[WIDTH-1:0];
          res_ovf    = !((prod_hi == '0) || (prod_hi == '1));
`ifdef ALU_SAT_EN
          res_neg    = sign_reg;
`endif
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

`ifdef ALU_SAT_EN
    res_final = res_ovf ? (res_neg ? MIN_V : MAX_V) : res_wrap;
`else
    res_final = res_wrap;
`endif

    if (update) begin
      data_next = res_final;
      zero_next = (res_final == '0);
      ovf_next  = res_ovf;
    end
  end

  assign bus.ready    = (state_reg == IDLE);
  assign bus.done     = (state_reg == DONE);
  assign bus.dataOut  = data_reg;
  assign bus.zeroFlag = zero_reg;
  assign bus.ovfFlag  = ovf_reg;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Self-checking bench for alu_seq at WIDTH=12: a directed vector table, a
// multiply with a start issued while busy, reset during a multiply, and
// randomized ops checked against an integer reference model.
// ---------------------------------------------------------------------------
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W    = 12;
  localparam int MAXV = 2047;
  localparam int MINV = -2048;
  localparam int LAT1 = 1;       // negedges from accept edge to done, single-cycle op
  localparam int LATM = W + 1;   // same for mul (done after edge t+W)

`ifdef ALU_SAT_EN
  localparam int E_POS_OVF = MAXV;
  localparam int E_MUL_OVF = MINV;
  localparam int E_NEG_OVF = MINV;
`else
  localparam int E_POS_OVF = MINV;
  localparam int E_MUL_OVF = 1596;
  localparam int E_NEG_OVF = MAXV;
`endif

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: last completed result and flags
  int m_data = 0;
  int m_zero = 1;
  int m_ovf  = 0;

  typedef struct {
    int op;
    int a;
    int b;
    int data;
    int zero;
    int ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int wrap12(input longint t);
    longint r;
    r = t % 4096;
    if (r < 0) r += 4096;
    if (r >= 2048) r -= 4096;
    return int'(r);
  endfunction

  // Behavioural model computed from plain integer arithmetic
  function automatic void model(input int op, input int a, input int b);
    longint t;
    int     w;
    bit     upd;
    bit     ov;
    upd = 1'b1;
    t   = 0;
    case (op)
      0:       t = 0;
      1:       t = a;
      2:       t = longint'(a) + b;
      3:       t = longint'(a) - b;
      4:       t = longint'(a) * b;
      5:       t = longint'(a) + 1;
      default: upd = 1'b0;
    endcase
    if (upd) begin
      ov = (op >= 2) && ((t > MAXV) || (t < MINV));
      w  = wrap12(t);
`ifdef ALU_SAT_EN
      if (ov) w = (t > 0) ? MAXV : MINV;
`endif
      m_data = w;
      m_zero = (w == 0) ? 1 : 0;
      m_ovf  = ov ? 1 : 0;
    end
  endfunction

  // Issue one op and follow it to done.
  // lat  : negedges from the accepting edge up to and including the done cycle
  // busy : how many of those cycles had ready=0
  // poke : raise start (add 1+1) while busy to confirm it is ignored
  task automatic run_op(input int op, input int a, input int b, input bit poke,
                        output int lat, output int busy,
                        output int done_after, output int ready_after);
    int g;
    @(negedge clk);
    g = 0;
    while (!bus.ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!bus.ready) chk("ready_wait", 0, 1);
    bus.start    = 1'b1;
    bus.selectOp = 3'(op);
    bus.a        = W'(a);
    bus.b        = W'(b);
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.selectOp = 3'($urandom);
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    lat  = 0;
    busy = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (!bus.ready) busy++;
      if (poke && lat == 3) begin
        bus.start    = 1'b1;
        bus.selectOp = OP_ADD;
        bus.a        = W'(1);
        bus.b        = W'(1);
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) break;
    end
    bus.start = 1'b0;
    @(negedge clk);
    done_after  = int'(bus.done);
    ready_after = int'(bus.ready);
  endtask

  task automatic check_txn(input string name, input int op, input int a, input int b,
                           input bit poke, input int e_data, input int e_zero,
                           input int e_ovf);
    int lat, busy, dn, rd, e_lat, got;
    e_lat = (op == 4) ? LATM : LAT1;
    run_op(op, a, b, poke, lat, busy, dn, rd);
    got = int'($signed(bus.dataOut));
    $display("txn %s op=%0d a=%0d b=%0d -> data=%0d zero=%0d ovf=%0d lat=%0d busy=%0d",
             name, op, a, b, got, bus.zeroFlag, bus.ovfFlag, lat, busy);
    chk({name, ".data"}, got, e_data);
    chk({name, ".zero"}, int'(bus.zeroFlag), e_zero);
    chk({name, ".ovf"}, int'(bus.ovfFlag), e_ovf);
    chk({name, ".lat"}, lat, e_lat);
    chk({name, ".busy"}, busy, e_lat);
    chk({name, ".done_pulse"}, dn, 0);
    chk({name, ".ready_after"}, rd, 1);
  endtask

  initial begin
    int extra_done, a_r, b_r, op_r, cyc;
    int pick[5];

    bus.start    = 1'b0;
    bus.selectOp = 3'd0;
    bus.a        = '0;
    bus.b        = '0;

    vecs[0]  = '{op: 2, a: 10,    b: 3,   data: 13,        zero: 0, ovf: 0};
    vecs[1]  = '{op: 3, a: 20,    b: -30, data: 50,        zero: 0, ovf: 0};
    vecs[2]  = '{op: 2, a: 2047,  b: 1,   data: E_POS_OVF, zero: 0, ovf: 1};
    vecs[3]  = '{op: 5, a: 2047,  b: 0,   data: E_POS_OVF, zero: 0, ovf: 1};
    vecs[4]  = '{op: 4, a: -50,   b: 50,  data: E_MUL_OVF, zero: 0, ovf: 1};
    vecs[5]  = '{op: 4, a: -2048, b: 1,   data: -2048,     zero: 0, ovf: 0};
    vecs[6]  = '{op: 0, a: 123,   b: 45,  data: 0,         zero: 1, ovf: 0};
    vecs[7]  = '{op: 6, a: 77,    b: 88,  data: 0,         zero: 1, ovf: 0};
    vecs[8]  = '{op: 3, a: -2048, b: 1,   data: E_NEG_OVF, zero: 0, ovf: 1};
    vecs[9]  = '{op: 7, a: 5,     b: 5,   data: E_NEG_OVF, zero: 0, ovf: 1};
    vecs[10] = '{op: 1, a: -7,    b: 99,  data: -7,        zero: 0, ovf: 0};
    vecs[11] = '{op: 2, a: -5,    b: 5,   data: 0,         zero: 1, ovf: 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.data",  int'($signed(bus.dataOut)), 0);
    chk("rst.zero",  int'(bus.zeroFlag), 1);
    chk("rst.ovf",   int'(bus.ovfFlag), 0);
    chk("rst.done",  int'(bus.done), 0);
    chk("rst.ready", int'(bus.ready), 1);
    rstN = 1'b1;

    // Directed vectors
    for (int i = 0; i < 12; i++) begin
      model(vecs[i].op, vecs[i].a, vecs[i].b);
      check_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 1'b0,
                vecs[i].data, vecs[i].zero, vecs[i].ovf);
    end

    // mul 10*3 with a start raised while busy: must be ignored
    model(4, 10, 3);
    check_txn("mul_busy", 4, 10, 3, 1'b1, 30, 0, 0);
    extra_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) extra_done++;
    end
    chk("mul_busy.extra_done", extra_done, 0);
    chk("mul_busy.hold", int'($signed(bus.dataOut)), 30);

    // Reset asserted in the 5th cycle of a multiply
    @(negedge clk);
    bus.start    = 1'b1;
    bus.selectOp = OP_MUL;
    bus.a        = W'(7);
    bus.b        = W'(9);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rstN = 1'b0;
    #1;
    chk("abort.data",  int'($signed(bus.dataOut)), 0);
    chk("abort.zero",  int'(bus.zeroFlag), 1);
    chk("abort.ovf",   int'(bus.ovfFlag), 0);
    chk("abort.done",  int'(bus.done), 0);
    chk("abort.ready", int'(bus.ready), 1);
    extra_done = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done) extra_done++;
    end
    rstN = 1'b1;
    for (cyc = 0; cyc < W + 4; cyc++) begin
      @(negedge clk);
      if (bus.done) extra_done++;
    end
    chk("abort.no_done", extra_done, 0);
    $display("txn abort mul 7*9 by reset -> data=%0d done_seen=%0d",
             int'($signed(bus.dataOut)), extra_done);
    m_data = 0;
    m_zero = 1;
    m_ovf  = 0;
    model(2, 1, 1);
    check_txn("after_rst", 2, 1, 1, 1'b0, 2, 0, 0);

    // Randomized ops against the reference model
    pick[0] = MINV; pick[1] = -1; pick[2] = 0; pick[3] = 1; pick[4] = MAXV;
    for (int i = 0; i < 150; i++) begin
      op_r = int'($urandom_range(0, 7));
      a_r  = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)]
                                         : int'($urandom_range(0, 4095)) - 2048;
      b_r  = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)]
                                         : int'($urandom_range(0, 4095)) - 2048;
      model(op_r, a_r, b_r);
      check_txn($sformatf("rnd%0d", i), op_r, a_r, b_r, 1'b0, m_data, m_zero, m_ovf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
